mux17_sparse_sched: RTL and testbench



---
 rtl/mux17_sparse_sched.sv | 86 ++++++++
 tb/tb_mux17_sparse_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mux17_sparse_sched.sv
// Issue scheduler for the registered 17:1 select mux: streams the lane index of
// every set mask bit in ascending order, or a single zero-lane select (16) for an empty mask.
module mux17_sparse_sched #(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mask_valid,
  input  logic [NUM_IN-1:0] mask,
  output logic              mask_ready,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              last,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t            r_state;
  logic [NUM_IN-1:0] r_pending;
  logic              r_empty_grp;
  logic [CNT_W-1:0]  r_beat_idx;

  logic [SEL_W-1:0]  w_low_idx;
  logic              w_one_left;
  logic              w_issue;
  logic              w_fire;
  logic              w_load;

  // NOTE: scanning downward with a default first lets the lowest set bit win and keeps this a pure mux, no latch.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = SEL_W'(i);
    end
  end

  // Exactly one bit left when clearing the lowest set bit leaves nothing.
  assign w_one_left = (r_pending != '0) && ((r_pending & (r_pending - NUM_IN'(1))) == '0);

  assign w_issue    = (r_state == ISSUE);
  assign sel_valid  = w_issue;
  assign busy       = w_issue;
  assign sel        = !w_issue   ? '0 :
                      r_empty_grp ? SEL_W'(NUM_IN) : w_low_idx;
  assign last       = w_issue && (r_empty_grp || w_one_left);
  assign beat_idx   = r_beat_idx;

  // The last-beat fire frees the scheduler in the same cycle, giving bubble-free groups.
  assign mask_ready = !w_issue || (last && sel_ready);
  assign w_fire     = sel_valid && sel_ready;
  assign w_load     = mask_valid && mask_ready;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_empty_grp <= 1'b0;
      r_beat_idx  <= '0;
    end else if (w_load) begin
      r_state     <= ISSUE;
      r_pending   <= mask;
      r_empty_grp <= (mask == '0);
      r_beat_idx  <= '0;
    end else if (w_fire) begin
      if (last) begin
        r_state     <= IDLE;
        r_pending   <= '0;
        r_empty_grp <= 1'b0;
        r_beat_idx  <= '0;
      end else begin
        r_pending  <= r_pending & (r_pending - NUM_IN'(1));
        r_beat_idx <= r_beat_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux17_sparse_sched.sv
// Directed bench for mux17_sparse_sched: hand-computed select streams, stalls,
// back-to-back groups and mid-group reset.
module tb_mux17_sparse_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        mask_valid;
  logic [15:0] mask;
  logic        mask_ready;
  logic        sel_valid;
  logic        sel_ready;
  logic [4:0]  sel;
  logic        last;
  logic [3:0]  beat_idx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int fire_cnt = 0;

  always #5 clk = ~clk;

  mux17_sparse_sched dut (
    .clk        (clk),
    .reset      (reset),
    .mask_valid (mask_valid),
    .mask       (mask),
    .mask_ready (mask_ready),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel        (sel),
    .last       (last),
    .beat_idx   (beat_idx),
    .busy       (busy)
  );

  always @(posedge clk) if (sel_valid && sel_ready) fire_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input int e_sel, input int e_last,
                      input int e_idx, input int e_mrdy);
    check({tag, ".valid"}, sel_valid, 1);
    check({tag, ".sel"}, sel, e_sel);
    check({tag, ".last"}, last, e_last);
    check({tag, ".beat_idx"}, beat_idx, e_idx);
    check({tag, ".mask_ready"}, mask_ready, e_mrdy);
  endtask

  task automatic idle(input string tag);
    check({tag, ".valid"}, sel_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".mask_ready"}, mask_ready, 1);
  endtask

  initial begin
    int fires0;
    reset = 1'b1; mask_valid = 1'b0; mask = '0; sel_ready = 1'b0;
    repeat (2) @(posedge clk);
    nxt(); reset = 1'b0; #1;
    check("rst.mask_ready", mask_ready, 1);
    check("rst.sel_valid", sel_valid, 0);
    check("rst.sel", sel, 0);
    check("rst.last", last, 0);
    check("rst.beat_idx", beat_idx, 0);
    check("rst.busy", busy, 0);

    // 8421: lanes 0,5,10,15
    mask_valid = 1'b1; mask = 16'h8421; sel_ready = 1'b1;
    nxt(); mask_valid = 1'b0; #1; beat("m8421.b0", 0, 0, 0, 0);
    check("m8421.busy", busy, 1);
    nxt(); #1; beat("m8421.b1", 5, 0, 1, 0);
    nxt(); #1; beat("m8421.b2", 10, 0, 2, 0);
    nxt(); #1; beat("m8421.b3", 15, 1, 3, 1);
    nxt(); #1; idle("m8421.done");

    // empty mask: one zero-lane beat
    mask_valid = 1'b1; mask = 16'h0000;
    nxt(); mask_valid = 1'b0; #1; beat("m0000.b0", 16, 1, 0, 1);
    nxt(); #1; idle("m0000.done");

    // FFFF then 0003 back-to-back with mask_valid held
    mask_valid = 1'b1; mask = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      nxt();
      if (i == 0) mask = 16'h0003;
      #1; beat($sformatf("mFFFF.b%0d", i), i, (i == 15), i, (i == 15));
    end
    nxt(); mask_valid = 1'b0; #1; beat("m0003.b0", 0, 0, 0, 0);
    nxt(); #1; beat("m0003.b1", 1, 1, 1, 1);
    nxt(); #1; idle("m0003.done");

    // 0110 with sel_ready 0,0,1,0,1
    mask_valid = 1'b1; mask = 16'h0110; sel_ready = 1'b0;
    @(posedge clk); fires0 = fire_cnt;
    nxt(); mask_valid = 1'b0; mask = 16'hFFFF; sel_ready = 1'b0; #1; beat("stall.c1", 4, 0, 0, 0);
    nxt(); sel_ready = 1'b0; #1; beat("stall.c2", 4, 0, 0, 0);
    nxt(); sel_ready = 1'b1; #1; beat("stall.c3", 4, 0, 0, 0);
    nxt(); sel_ready = 1'b0; #1; beat("stall.c4", 8, 1, 1, 0);
    nxt(); sel_ready = 1'b1; #1; beat("stall.c5", 8, 1, 1, 1);
    nxt(); #1; idle("stall.done");
    check("stall.fires", fire_cnt - fires0, 2);

    // reset on the second beat of 00F0
    mask_valid = 1'b1; mask = 16'h00F0;
    nxt(); mask_valid = 1'b0; #1; beat("rstmid.b0", 4, 0, 0, 0);
    nxt(); #1; beat("rstmid.b1", 5, 0, 1, 0); reset = 1'b1;
    nxt(); reset = 1'b0; #1; idle("rstmid.after");
    check("rstmid.beat_idx", beat_idx, 0);
    mask_valid = 1'b1; mask = 16'h0001;
    nxt(); mask_valid = 1'b0; #1; beat("m0001.b0", 0, 1, 0, 1);
    nxt(); #1; idle("m0001.done");
    nxt(); #1; idle("m0001.quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
